// File: rtl/pipelined_addsub_if.sv
// rtl/pipelined_addsub_if.sv - operand/result handshake bundle for the pipelined adder/subtractor
interface pipelined_addsub_if #(
    parameter int N = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         sel;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] OUT;
    logic         CarryOut;
    logic         Overflow;
    logic         Zero;
    logic         Negative;

    // Operand producer / result consumer side
    modport master (
        output in_valid, A, B, sel, out_ready,
        input  in_ready, out_valid, OUT, CarryOut, Overflow, Zero, Negative
    );

    // Arithmetic block side
    modport slave (
        input  in_valid, A, B, sel, out_ready,
        output in_ready, out_valid, OUT, CarryOut, Overflow, Zero, Negative
    );
endinterface

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - segmented, carry-registered pipelined adder/subtractor with status flags
module pipelined_addsub #(
    parameter int N   = 32,
    parameter int SEG = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_addsub_if.slave    bus
);
    localparam int S = N / SEG;

    if ((SEG < 1) || (N % SEG != 0)) begin : g_bad_seg
        $error("pipelined_addsub: N must be a non-zero multiple of SEG");
    end

    // ready[k] is the advance condition of stage k; ready[S] is the consumer.
    logic [S:0]   ready;
    // vin[k] is the valid bit offered to stage k.
    logic [S-1:0] vin;
    // Data offered to stage k. Operands are kept right-aligned so the segment
    // to be processed next always sits in bits [SEG-1:0]; B is already
    // conditionally inverted, so sel lives on only as the initial carry-in.
    logic [N-1:0] ina   [S];
    logic [N-1:0] inb   [S];
    logic [N-1:0] resin [S];
    logic         cin   [S];

    assign ready[S]     = bus.out_ready;
    assign bus.in_ready = ready[0] && !rst;
    assign vin[0]       = bus.in_valid && bus.in_ready;
    assign ina[0]       = bus.A;
    assign inb[0]       = bus.B ^ {N{bus.sel}};
    assign cin[0]       = bus.sel;
    assign resin[0]     = '0;

    for (genvar k = 0; k < S; k++) begin : g_st
        logic         valid_q;
        logic [N-1:0] res_q;
        logic         carry_q;
        logic [SEG:0] sum;
        logic [N-1:0] res_d;

        assign sum = {1'b0, ina[k][SEG-1:0]} + {1'b0, inb[k][SEG-1:0]} + {{SEG{1'b0}}, cin[k]};

        // Merge this stage's segment into the partial result
        always_comb begin
            res_d                = resin[k];
            res_d[k*SEG +: SEG]  = sum[SEG-1:0];
        end

        assign ready[k] = !valid_q || ready[k+1];

        // Stage valid/result/carry: advance when downstream has room, load data only for a real op
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                res_q   <= '0;
                carry_q <= 1'b0;
            end else if (ready[k]) begin
                valid_q <= vin[k];
                if (vin[k]) begin
                    res_q   <= res_d;
                    carry_q <= sum[SEG];
                end
            end
        end

        if (k < S-1) begin : g_ops
            logic [N-1:0] a_q;
            logic [N-1:0] b_q;

            // Remaining operand bits, shifted down so the next segment is at the bottom
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (ready[k] && vin[k]) begin
                    a_q <= ina[k] >> SEG;
                    b_q <= inb[k] >> SEG;
                end
            end

            assign ina[k+1]   = a_q;
            assign inb[k+1]   = b_q;
            assign cin[k+1]   = carry_q;
            assign resin[k+1] = res_q;
            assign vin[k+1]   = valid_q;
        end else begin : g_last
            logic ovf_q;
            logic zero_q;
            logic c_msb;

            // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in
            assign c_msb = sum[SEG-1] ^ ina[k][SEG-1] ^ inb[k][SEG-1];

            // Final-stage flags registered alongside the result
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (ready[k] && vin[k]) begin
                    ovf_q  <= c_msb ^ sum[SEG];
                    zero_q <= (res_d == '0);
                end
            end

            assign bus.out_valid = valid_q;
            assign bus.OUT       = res_q;
            assign bus.CarryOut  = carry_q;
            assign bus.Overflow  = ovf_q;
            assign bus.Zero      = zero_q;
            assign bus.Negative  = res_q[N-1];
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub at S=4, S=1 and S=8
module tb_pipelined_addsub;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic [3:0]  f;   // {CarryOut, Overflow, Zero, Negative}
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s       [3];
    logic        in_valid_s  [3];
    logic        sel_s       [3];
    logic        out_ready_s [3];
    logic [31:0] a_s         [3];
    logic [31:0] b_s         [3];
    logic        in_ready_s  [3];
    logic        out_valid_s [3];
    logic [31:0] out_s       [3];
    logic [3:0]  flg_s       [3];

    pipelined_addsub_if #(.N(32)) if0 ();
    pipelined_addsub_if #(.N(16)) if1 ();
    pipelined_addsub_if #(.N(32)) if2 ();

    pipelined_addsub #(.N(32), .SEG(8))  u0 (.clk(clk), .rst(rst_s[0]), .bus(if0.slave));
    pipelined_addsub #(.N(16), .SEG(16)) u1 (.clk(clk), .rst(rst_s[1]), .bus(if1.slave));
    pipelined_addsub #(.N(32), .SEG(4))  u2 (.clk(clk), .rst(rst_s[2]), .bus(if2.slave));

    assign if0.in_valid  = in_valid_s[0];
    assign if0.A         = a_s[0];
    assign if0.B         = b_s[0];
    assign if0.sel       = sel_s[0];
    assign if0.out_ready = out_ready_s[0];
    assign in_ready_s[0]  = if0.in_ready;
    assign out_valid_s[0] = if0.out_valid;
    assign out_s[0]       = if0.OUT;
    assign flg_s[0]       = {if0.CarryOut, if0.Overflow, if0.Zero, if0.Negative};

    assign if1.in_valid  = in_valid_s[1];
    assign if1.A         = a_s[1][15:0];
    assign if1.B         = b_s[1][15:0];
    assign if1.sel       = sel_s[1];
    assign if1.out_ready = out_ready_s[1];
    assign in_ready_s[1]  = if1.in_ready;
    assign out_valid_s[1] = if1.out_valid;
    assign out_s[1]       = {16'd0, if1.OUT};
    assign flg_s[1]       = {if1.CarryOut, if1.Overflow, if1.Zero, if1.Negative};

    assign if2.in_valid  = in_valid_s[2];
    assign if2.A         = a_s[2];
    assign if2.B         = b_s[2];
    assign if2.sel       = sel_s[2];
    assign if2.out_ready = out_ready_s[2];
    assign in_ready_s[2]  = if2.in_ready;
    assign out_valid_s[2] = if2.out_valid;
    assign out_s[2]       = if2.OUT;
    assign flg_s[2]       = {if2.CarryOut, if2.Overflow, if2.Zero, if2.Negative};

    int          errors = 0;
    int          checks = 0;
    int          sent;
    int          got;
    bit          acc_last;
    bit          last_in_ready;
    bit          prev_stall;
    logic [31:0] prev_out;
    res_t        exp_q[$];
    vec_t        t32[8];
    vec_t        t16[8];

    function automatic int wid(input int idx);
        return (idx == 1) ? 16 : 32;
    endfunction

    function automatic int stg(input int idx);
        return (idx == 0) ? 4 : ((idx == 1) ? 1 : 8);
    endfunction

    // Reference: plain modular arithmetic plus textbook signed-overflow rules
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t        o;
        logic [63:0] m, aa, bb, full, rr;
        logic        sa, sb, sr, c, v;
        m  = (64'd1 << w) - 64'd1;
        aa = {32'd0, a} & m;
        bb = {32'd0, b} & m;
        if (s) begin
            rr = (aa - bb) & m;
            c  = (aa >= bb);
        end else begin
            full = aa + bb;
            rr   = full & m;
            c    = full[w];
        end
        sa = aa[w-1];
        sb = bb[w-1];
        sr = rr[w-1];
        v  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        o.r = rr[31:0];
        o.f = {c, v, (rr == 64'd0), sr};
        return o;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] sgn;
        sgn = 32'd1 << (w - 1);
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return sgn;
            3:       return sgn - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got_v, exp_v, $time);
        end
    endtask

    // One handshake cycle; entered and left #1 after a rising edge
    task automatic step(input int idx, input bit want, input bit rdy);
        res_t e;
        out_ready_s[idx] = rdy;
        if (!(in_valid_s[idx] && !acc_last)) begin
            if (want) begin
                in_valid_s[idx] = 1'b1;
                a_s[idx]        = pick(wid(idx));
                b_s[idx]        = pick(wid(idx));
                sel_s[idx]      = 1'($urandom % 2);
            end else begin
                in_valid_s[idx] = 1'b0;
            end
        end
        @(negedge clk);
        last_in_ready = in_ready_s[idx];
        acc_last      = in_valid_s[idx] && in_ready_s[idx];
        if (acc_last) begin
            exp_q.push_back(model(wid(idx), a_s[idx], b_s[idx], sel_s[idx]));
            sent++;
        end
        if (prev_stall) begin
            chk("stall_valid", {31'd0, out_valid_s[idx]}, 32'd1);
            chk("stall_out", out_s[idx], prev_out);
        end
        if (out_valid_s[idx] && rdy) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_out", out_s[idx], e.r);
                chk("stream_flags", {28'd0, flg_s[idx]}, {28'd0, e.f});
            end
            got++;
        end
        prev_stall = out_valid_s[idx] && !rdy;
        prev_out   = out_s[idx];
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        in_valid_s[idx]  = 1'b1;
        a_s[idx]         = v.a;
        b_s[idx]         = v.b;
        sel_s[idx]       = v.s;
        out_ready_s[idx] = 1'b1;
        @(negedge clk);
        chk("vec_in_ready", {31'd0, in_ready_s[idx]}, 32'd1);
        @(posedge clk);
        #1;
        in_valid_s[idx] = 1'b0;
        lat = 0;
        while (!out_valid_s[idx] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("vec_latency", 32'(lat), 32'(stg(idx) - 1));
        chk("vec_out", out_s[idx], v.r);
        chk("vec_flags", {28'd0, flg_s[idx]}, {28'd0, v.f});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        sent       = 0;
        got        = 0;
        acc_last   = 1'b0;
        prev_stall = 1'b0;
    endtask

    initial begin
        int n;
        int stale;
        for (int i = 0; i < 3; i++) begin
            rst_s[i] = 1'b1; in_valid_s[i] = 1'b0; sel_s[i] = 1'b0;
            out_ready_s[i] = 1'b1; a_s[i] = '0; b_s[i] = '0;
        end
        t32[0] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_000C, 4'b0000};
        t32[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010};
        t32[2] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 4'b1000};
        t32[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 4'b0001};
        t32[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101};
        t32[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1100};
        t32[6] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 4'b1010};
        t32[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1110};
        t16[0] = '{32'h0005, 32'h0007, 1'b0, 32'h000C, 4'b0000};
        t16[1] = '{32'hFFFF, 32'h0001, 1'b0, 32'h0000, 4'b1010};
        t16[2] = '{32'h0007, 32'h0005, 1'b1, 32'h0002, 4'b1000};
        t16[3] = '{32'h0005, 32'h0007, 1'b1, 32'hFFFE, 4'b0001};
        t16[4] = '{32'h7FFF, 32'h0001, 1'b0, 32'h8000, 4'b0101};
        t16[5] = '{32'h8000, 32'h0001, 1'b1, 32'h7FFF, 4'b1100};
        t16[6] = '{32'h1234, 32'h1234, 1'b1, 32'h0000, 4'b1010};
        t16[7] = '{32'h8000, 32'h8000, 1'b0, 32'h0000, 4'b1110};

        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", {31'd0, in_ready_s[i]}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid_s[i]}, 32'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_in_ready", {31'd0, in_ready_s[i]}, 32'd1);
            chk("post_rst_out", out_s[i], 32'd0);
            chk("post_rst_flags", {28'd0, flg_s[i]}, 32'd0);
        end
        @(posedge clk);
        #1;

        for (int idx = 0; idx < 3; idx++) begin
            for (int j = 0; j < 8; j++) run_vec(idx, (idx == 1) ? t16[j] : t32[j]);

            clear_sb();
            n = 0;
            while (got < 16 && n < 3000) begin
                step(idx, (sent < 16) && ($urandom % 4 != 0), 1'($urandom % 2));
                n++;
            end
            chk("rand_count", 32'(got), 32'd16);
            chk("rand_leftover", 32'(exp_q.size()), 32'd0);

            clear_sb();
            n = 0;
            while (n < 20) begin
                step(idx, 1'b1, 1'b0);
                n++;
                if (!last_in_ready) break;
            end
            chk("cap_accepts", 32'(sent), 32'(stg(idx)));
            repeat (3) step(idx, 1'b1, 1'b0);
            step(idx, 1'b1, 1'b1);
            chk("drain_accept", {31'd0, acc_last}, 32'd1);
            n = 0;
            while (exp_q.size() != 0 && n < 40) begin
                step(idx, 1'b0, 1'b1);
                n++;
            end
            chk("cap_drained", 32'(exp_q.size()), 32'd0);
            chk("cap_total", 32'(got), 32'(stg(idx) + 1));

            clear_sb();
            repeat (3) step(idx, 1'b1, 1'b1);
            rst_s[idx]      = 1'b1;
            in_valid_s[idx] = 1'b0;
            @(negedge clk);
            chk("midrst_in_ready", {31'd0, in_ready_s[idx]}, 32'd0);
            @(posedge clk);
            #1;
            rst_s[idx] = 1'b0;
            #1;
            chk("midrst_out_valid", {31'd0, out_valid_s[idx]}, 32'd0);
            chk("midrst_out", out_s[idx], 32'd0);
            chk("midrst_flags", {28'd0, flg_s[idx]}, 32'd0);
            chk("midrst_in_ready_after", {31'd0, in_ready_s[idx]}, 32'd1);
            stale = 0;
            repeat (12) begin
                @(negedge clk);
                if (out_valid_s[idx]) stale++;
                @(posedge clk);
                #1;
            end
            chk("no_stale", 32'(stale), 32'd0);
            clear_sb();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the ALU's combinational ripple adder/subtractor.
- Splits the N-bit add/sub into N/SEG segment stages. Carry is registered between stages; one operation can be accepted per cycle.
- Valid/ready handshake on input and output; full stall/backpressure support.
- Produces real status flags: carry/no-borrow, signed overflow, zero, negative. It sits between the ALU operand mux and the writeback/flag logic.

Parameters:
- N, 32, operand/result width in bits.
- SEG, 8, segment width per pipeline stage; N % SEG == 0 required (elaboration error otherwise); S = N/SEG stages.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- A  input  N  operand A.
- B  input  N  operand B.
- sel  input  1  0 = A+B, 1 = A-B (A + ~B + 1).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- OUT  output  N  result.
- CarryOut  output  1  carry out of MSB; for subtraction 1 = no borrow (A >= B unsigned).
- Overflow  output  1  signed overflow.
- Zero  output  1  OUT == 0.
- Negative  output  1  OUT[N-1].

Behaviour:
- Stage registers 0..S-1. Each holds:
  - a valid bit;
  - completed low result segments;
  - the registered carry;
  - the remaining unprocessed A, B~^sel segments;
  - sel.
- Stage 0 load:
  - Occurs on input handshake (in_valid && in_ready).
  - Computes bits [SEG-1:0] from A, B^sel and carry-in = sel.
  - Stores the sum, carry and the upper operand bits.
- Stage k (1..S-1) load:
  - Computes bits [k*SEG +: SEG] from stage k-1 data and the registered carry.
  - Passes all results forward.
- Outputs are driven directly from stage S-1 registers; no combinational path from A/B to OUT.
- Latency: result of an op accepted at edge t is visible with out_valid=1 after edge t+S-1, i.e. S cycles from the accept cycle. SEG==N gives S=1: a single registered adder.
- Throughput: 1 op/cycle while out_ready=1.
- Flow control per stage:
  - ready_k = !valid_k || ready_{k+1};
  - ready_S = out_ready;
  - in_ready = ready_0.
  - A stage advances only when ready_k; otherwise it holds its data unchanged.
- Ordering and integrity:
  - Results emerge strictly in acceptance order.
  - No drop, duplicate or reorder under any out_ready pattern.
  - Output holds stable while out_valid && !out_ready.
- Capacity: S ops in flight. With out_ready=0 and all stages valid, in_ready=0.
- Simultaneous drain and accept: with a full pipe, out_ready=1 and in_valid=1 in the same cycle, the pipe shifts and accepts. There is no bubble.
- Flags (final stage), with c_msb = carry into bit N-1:
  - CarryOut = carry out of bit N-1.
  - Overflow = c_msb ^ CarryOut.
  - Zero = (OUT == 0).
  - Negative = OUT[N-1].
- Arithmetic is modulo 2^N; no saturation.
- Reset:
  - While rst=1, in_ready=0.
  - On the rst edge, all valid bits clear and OUT/flags reset to 0; out_valid=0.
  - The cycle after rst deasserts, in_ready=1.
- Reset mid-operation discards all in-flight ops; no stale result appears after reset.
- X-safety: operand registers update only on a stage advance. Idle stages do not toggle.

Test Plan:
- N=32, SEG=8, out_ready=1: add 5+7 -> OUT=0x0000000C, CarryOut=0, Overflow=0, Zero=0, Negative=0, out_valid exactly 4 cycles after accept.
- Add 0xFFFFFFFF+0x00000001 -> OUT=0, CarryOut=1, Zero=1, Overflow=0 (carry ripples through all 4 stages). Sub 7-5 -> OUT=2, CarryOut=1. Sub 5-7 -> OUT=0xFFFFFFFE, CarryOut=0, Negative=1.
- Add 0x7FFFFFFF+1 -> OUT=0x80000000, Overflow=1, Negative=1. Sub 0x80000000-1 -> OUT=0x7FFFFFFF, Overflow=1. Sub 0x12345678-0x12345678 -> Zero=1, CarryOut=1.
- Stream 16 random ops back-to-back, out_ready pseudo-random 50%:
  - all results match the reference model, in order, none lost or duplicated;
  - with out_ready held 0, in_ready drops after exactly 4 accepts;
  - OUT is stable while stalled;
  - the full-pipe drain+accept cycle accepts the new op.
- Accept 3 ops, assert rst for 1 cycle mid-flight -> out_valid=0 and OUT=0 next cycle, in_ready=0 during rst and 1 after, and no stale result ever appears.
- Re-elaborate with N=16, SEG=16 (S=1) and N=32, SEG=4 (S=8): repeat the corner vectors scaled to width -> latency 1 and 8 respectively, identical flag behaviour.
